cmd_addr_sequencer: RTL and testbench
=====================================

CMD_ADDR_SEQUENCER -- requirements
Module: cmd_addr_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, max clk cycles allowed per latch operation (activate to busy-low).
REQ-002 Parameter MAX_ADDR_CYCLES, default 5, largest legal address-cycle count.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 start  in  1  request strobe, sampled only while ready=1.
REQ-007 cmd0  in  8  first command opcode.
REQ-008 addr  in  40  address bytes; addr[7:0] is issued first.
REQ-009 addr_cycles  in  3  number of address bytes, 0..MAX_ADDR_CYCLES.
REQ-010 has_cmd1  in  1  1 = issue a second command after the address bytes.
REQ-011 cmd1  in  8  second command opcode (e.g. 0x30 confirm).
REQ-012 ready  out  1  idle; request may be accepted.
REQ-013 done  out  1  one-cycle pulse: sequence completed.
REQ-014 error  out  1  one-cycle pulse: invalid request or timeout.
REQ-015 latch_activate  out  1  one-cycle strobe to the downstream command/address latch unit.
REQ-016 latch_data  out  16  byte to latch, zero-extended ({8'h00, byte}).
REQ-017 latch_type  out  1  `LATCH_CMD for command bytes, `LATCH_ADDR for address bytes.
REQ-018 latch_busy  in  1  busy from the latch unit; rises one cycle after the activate is sampled.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 States SHALL be IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE.
REQ-021 IDLE: ready=1; start=1 captures cmd0, addr, addr_cycles, has_cmd1, cmd1; later input changes are ignored.
REQ-022 Byte order SHALL be cmd0, then addr bytes 0..addr_cycles-1 (LSB first), then cmd1 if has_cmd1=1.
REQ-023 ISSUE: latch_activate=1 for exactly one cycle with latch_data/latch_type valid; next state WAIT_HI.
REQ-024 latch_data and latch_type SHALL hold their value from ISSUE until the exit from WAIT_LO.
REQ-025 WAIT_HI: remain until latch_busy=1, then WAIT_LO.
REQ-026 WAIT_LO: remain until latch_busy=0; then ISSUE if bytes remain, else DONE.
REQ-027 The first latch_activate SHALL occur in the cycle after start is accepted; each subsequent activate SHALL occur in the cycle after latch_busy=0 is sampled in WAIT_LO.
REQ-028 DONE: done=1 for one cycle, ready=0; next state IDLE, ready=1 in the following cycle.
REQ-029 ready SHALL be 0 from the cycle after start is accepted through the DONE cycle; start while ready=0 SHALL be ignored.
REQ-030 addr_cycles > MAX_ADDR_CYCLES at start: no latch_activate; error=1 in the next cycle; done stays 0; return to IDLE.
REQ-031 addr_cycles=0, has_cmd1=0: exactly one latch operation (cmd0) before done.
REQ-032 A timeout counter SHALL clear on each ISSUE and increment in WAIT_HI/WAIT_LO; on reaching TIMEOUT_CYCLES: error=1 for one cycle, latch_activate=0, done=0, next state IDLE.
REQ-033 done and error SHALL never be asserted in the same cycle.

Reset
REQ-034 On reset=1 at a clock edge: state=IDLE, ready=1, done=0, error=0, latch_activate=0, latch_data=0, latch_type=`LATCH_CMD, timeout counter=0.
REQ-035 Reset SHALL take priority over all other inputs, including mid-sequence; the captured request SHALL be discarded, and no further activate SHALL be issued.

Verification
REQ-036 cmd0=0x00, addr=0x00_0002_0100, addr_cycles=5, has_cmd1=1, cmd1=0x30, latch model busy for 4 cycles -> latch_data sequence 0x0000, 0x0000, 0x0001, 0x0002, 0x0000, 0x0000, 0x0030; types CMD, ADDR x5, CMD; 7 activates; one done pulse.
REQ-037 cmd0=0xFF, addr_cycles=0, has_cmd1=0 -> single activate (data 0x00FF, CMD); done 1 cycle after busy falls; ready high 1 cycle later.
REQ-038 addr_cycles=6 -> error pulse in the cycle after start; zero activates; ready back to 1.
REQ-039 latch_busy held 0 after activate, TIMEOUT_CYCLES=16 -> error pulse 16 cycles after ISSUE; no done; ready returns to 1.
REQ-040 reset asserted during the third byte's WAIT_LO -> all outputs at reset values the next cycle; no further activates; new start accepted afterwards.
REQ-041 start pulsed while ready=0 during a sequence -> ignored; the original byte sequence and a single done are unchanged.

Source files
------------

// File: rtl/cmd_addr_sequencer_if.sv
// Request/status and latch-unit bundle for cmd_addr_sequencer.
// Latency: none (wires only).
// Backpressure: none here; the sequencer paces itself on ready and latch_busy.
//
// Signals:
//   request side : start, cmd0, addr, addr_cycles, has_cmd1, cmd1 (to sequencer)
//                  ready, done, error (from sequencer)
//   latch side   : latch_activate, latch_data, latch_type (from sequencer)
//                  latch_busy (to sequencer)
// Modports: slave = sequencer, master = requester, latch_unit = downstream latch.

`ifndef LATCH_CMD
`define LATCH_CMD 1'b0
`endif
`ifndef LATCH_ADDR
`define LATCH_ADDR 1'b1
`endif

interface cmd_addr_sequencer_if;
  logic        start;
  logic [7:0]  cmd0;
  logic [39:0] addr;
  logic [2:0]  addr_cycles;
  logic        has_cmd1;
  logic [7:0]  cmd1;
  logic        ready;
  logic        done;
  logic        error;
  logic        latch_activate;
  logic [15:0] latch_data;
  logic        latch_type;
  logic        latch_busy;

  modport slave (
    input  start, cmd0, addr, addr_cycles, has_cmd1, cmd1, latch_busy,
    output ready, done, error, latch_activate, latch_data, latch_type
  );

  modport master (
    output start, cmd0, addr, addr_cycles, has_cmd1, cmd1,
    input  ready, done, error
  );

  modport latch_unit (
    input  latch_activate, latch_data, latch_type,
    output latch_busy
  );
endinterface

// File: rtl/cmd_addr_sequencer.sv
// Issues cmd0, addr bytes (LSB first) and optional cmd1 to a command/address latch unit.
// Latency: first activate 1 cycle after start; each next activate 1 cycle after busy falls.
// Backpressure: waits on latch_busy high then low per byte; start only taken while ready=1.
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : cmd_addr_sequencer_if.slave (request fields in, ready/done/error out,
//           latch_activate/latch_data/latch_type out, latch_busy in)

`ifndef LATCH_CMD
`define LATCH_CMD 1'b0
`endif
`ifndef LATCH_ADDR
`define LATCH_ADDR 1'b1
`endif

module cmd_addr_sequencer #(
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int MAX_ADDR_CYCLES = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  cmd_addr_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    DONE
  } state_t;

  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  // addr is 40 bits wide, so the limit can never meaningfully exceed 5.
  localparam logic [3:0]       MAX_AC  = 4'(MAX_ADDR_CYCLES);

  state_t            state_q, state_d;

  // Request captured at accept; the bus fields are ignored afterwards.
  logic [7:0]        cmd0_q;
  logic [39:0]       addr_q;
  logic [2:0]        ac_q;
  logic [7:0]        cmd1_q;
  logic [3:0]        tot_q;      // total bytes in this sequence
  logic [3:0]        idx_q, idx_d; // bytes issued so far

  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              act_q, act_d;
  logic [15:0]       data_q, data_d;
  logic              type_q, type_d;

  logic              accept;
  logic              capture;
  logic              to_hit;
  logic [39:0]       addr_sh;
  logic [7:0]        next_byte;
  logic              next_type;

  // Gating on ready_q keeps a start in the error cycle from being taken.
  assign accept = (state_q == IDLE) && ready_q && bus.start;

  // cnt_q holds cycles elapsed since the ISSUE cycle; the register pulses
  // error exactly TIMEOUT_CYCLES cycles after the activate.
  assign to_hit = (cnt_q >= TO_LAST);

  assign addr_sh = addr_q >> {idx_q - 4'd1, 3'b000};

  // Byte selection for the next ISSUE. The first byte comes straight off the
  // bus because the request registers are only loaded on the same edge.
  always_comb begin
    next_byte = cmd1_q;
    next_type = `LATCH_CMD;
    if (capture) begin
      next_byte = bus.cmd0;
      next_type = `LATCH_CMD;
    end else if (idx_q == 4'd0) begin
      next_byte = cmd0_q;
      next_type = `LATCH_CMD;
    end else if (idx_q <= {1'b0, ac_q}) begin
      next_byte = addr_sh[7:0];
      next_type = `LATCH_ADDR;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    error_d = 1'b0;
    capture = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if ({1'b0, bus.addr_cycles} > MAX_AC) begin
            error_d = 1'b1;
          end else begin
            capture = 1'b1;
            idx_d   = 4'd0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        idx_d   = idx_q + 4'd1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = WAIT_HI;
      end
      WAIT_HI: begin
        if (to_hit) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (bus.latch_busy) begin
            state_d = WAIT_LO;
          end
        end
      end
      WAIT_LO: begin
        if (to_hit) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!bus.latch_busy) begin
            state_d = (idx_q < tot_q) ? ISSUE : DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == ISSUE) begin
      cnt_d = '0;
    end
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe.
  always_comb begin
    ready_d = (state_d == IDLE) && !error_d;
    done_d  = (state_d == DONE);
    act_d   = (state_d == ISSUE);
    data_d  = data_q;
    type_d  = type_q;
    // Data/type are only reloaded on ISSUE so they stay stable for the whole
    // latch handshake.
    if (state_d == ISSUE) begin
      data_d = {8'h00, next_byte};
      type_d = next_type;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cmd0_q  <= '0;
      addr_q  <= '0;
      ac_q    <= '0;
      cmd1_q  <= '0;
      tot_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      act_q   <= 1'b0;
      data_q  <= '0;
      type_q  <= `LATCH_CMD;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      error_q <= error_d;
      act_q   <= act_d;
      data_q  <= data_d;
      type_q  <= type_d;
      if (capture) begin
        cmd0_q <= bus.cmd0;
        addr_q <= bus.addr;
        ac_q   <= bus.addr_cycles;
        cmd1_q <= bus.cmd1;
        tot_q  <= {1'b0, bus.addr_cycles} + 4'd1 + {3'b000, bus.has_cmd1};
      end
    end
  end

  assign bus.ready          = ready_q;
  assign bus.done           = done_q;
  assign bus.error          = error_q;
  assign bus.latch_activate = act_q;
  assign bus.latch_data     = data_q;
  assign bus.latch_type     = type_q;

endmodule

// File: tb/tb_cmd_addr_sequencer.sv
// Directed bench for cmd_addr_sequencer with a 4-cycle busy latch model.
// Latency: n/a.
// Backpressure: latch model raises busy one cycle after each sampled activate.

module tb_cmd_addr_sequencer;

  localparam bit T_CMD  = 1'b0;
  localparam bit T_ADDR = 1'b1;
  localparam int BUSY_LEN = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;
  int   busy_cnt;
  bit   model_en;
  int   both_cnt;

  int          act_cyc[$];
  logic [15:0] act_dat[$];
  logic        act_typ[$];
  int          done_cyc[$];
  int          err_cyc[$];

  cmd_addr_sequencer_if bus ();

  cmd_addr_sequencer #(
    .TIMEOUT_CYCLES  (16),
    .MAX_ADDR_CYCLES (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Latch unit model: busy high for BUSY_LEN cycles starting the cycle after
  // an activate is sampled.
  always @(posedge clk) begin
    if (reset) busy_cnt <= 0;
    else if (model_en && bus.latch_activate) busy_cnt <= BUSY_LEN;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.latch_busy = (busy_cnt != 0);

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.latch_activate) begin
        act_cyc.push_back(cyc);
        act_dat.push_back(bus.latch_data);
        act_typ.push_back(bus.latch_type);
      end
      if (bus.done)  done_cyc.push_back(cyc);
      if (bus.error) err_cyc.push_back(cyc);
      if (bus.done && bus.error) both_cnt++;
    end
  end

  task automatic clear_log();
    act_cyc.delete();
    act_dat.delete();
    act_typ.delete();
    done_cyc.delete();
    err_cyc.delete();
  endtask

  task automatic start_req(input logic [7:0] c0, input logic [39:0] a, input logic [2:0] ac,
                           input logic h1, input logic [7:0] c1, output int acc);
    @(negedge clk); #1;
    bus.cmd0 = c0; bus.addr = a; bus.addr_cycles = ac; bus.has_cmd1 = h1; bus.cmd1 = c1;
    bus.start = 1'b1;
    acc = cyc + 1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    // Scramble the request fields; the DUT must work from its captured copy.
    bus.cmd0 = 8'hA5; bus.addr = 40'hDE_ADBE_EF55; bus.addr_cycles = 3'd1;
    bus.has_cmd1 = ~h1; bus.cmd1 = 8'h5A;
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (done_cyc.size() == 0 && err_cyc.size() == 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_cyc.size() == 0 && err_cyc.size() == 0) begin
      checks++; errors++;
      $display("FAIL wait_end: no done/error within %0d cycles", budget);
    end
  endtask

  task automatic wait_acts(input int n_acts, input int budget);
    int n;
    n = 0;
    while (act_cyc.size() < n_acts && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (act_cyc.size() < n_acts) begin
      checks++; errors++;
      $display("FAIL wait_acts: got %0d activates, required %0d", act_cyc.size(), n_acts);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.error !== 1'b0 ||
        bus.latch_activate !== 1'b0 || bus.latch_data !== 16'h0000 || bus.latch_type !== T_CMD) begin
      errors++;
      $display("FAIL reset_state: rdy=%b done=%b err=%b act=%b data=%h type=%b, required 1 0 0 0 0000 0",
               bus.ready, bus.done, bus.error, bus.latch_activate, bus.latch_data, bus.latch_type);
    end
  endtask

  task automatic test_full_sequence();
    int acc;
    logic [15:0] exp_d [7];
    logic        exp_t [7];
    exp_d = '{16'h0000, 16'h0000, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 16'h0030};
    exp_t = '{T_CMD, T_ADDR, T_ADDR, T_ADDR, T_ADDR, T_ADDR, T_CMD};
    clear_log();
    start_req(8'h00, 40'h00_0002_0100, 3'd5, 1'b1, 8'h30, acc);
    wait_end(100);
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++; $display("FAIL full_ready_in_done: got %b, required 0", bus.ready);
    end
    checks++;
    if (act_cyc.size() != 7) begin
      errors++; $display("FAIL full_act_count: got %0d, required 7", act_cyc.size());
    end
    for (int i = 0; i < 7 && i < act_cyc.size(); i++) begin
      checks++;
      if (act_dat[i] !== exp_d[i] || act_typ[i] !== exp_t[i] || act_cyc[i] != acc + 6 * i) begin
        errors++;
        $display("FAIL full_byte%0d: data=%h type=%b cyc=%0d, required %h %b %0d",
                 i, act_dat[i], act_typ[i], act_cyc[i], exp_d[i], exp_t[i], acc + 6 * i);
      end
    end
    checks++;
    if (done_cyc.size() != 1 || err_cyc.size() != 0 || (done_cyc.size() == 1 && done_cyc[0] != acc + 42)) begin
      errors++;
      $display("FAIL full_done: done pulses=%0d err pulses=%0d, required 1 at cycle %0d and 0",
               done_cyc.size(), err_cyc.size(), acc + 42);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++; $display("FAIL full_ready_after: got %b, required 1", bus.ready);
    end
  endtask

  task automatic test_single_cmd();
    int acc;
    clear_log();
    start_req(8'hFF, 40'h12_3456_789A, 3'd0, 1'b0, 8'h30, acc);
    wait_end(40);
    checks++;
    if (act_cyc.size() != 1 || (act_cyc.size() == 1 && (act_dat[0] !== 16'h00FF || act_typ[0] !== T_CMD))) begin
      errors++;
      $display("FAIL single_act: count=%0d, required 1 activate data 00ff type CMD", act_cyc.size());
    end
    checks++;
    if (done_cyc.size() != 1 || (done_cyc.size() == 1 && done_cyc[0] != acc + 6) || bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL single_done: pulses=%0d ready=%b, required 1 at cycle %0d with ready 0",
               done_cyc.size(), bus.ready, acc + 6);
    end
    @(negedge clk); #1;
    checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
      errors++; $display("FAIL single_ready_after: ready=%b done=%b, required 1 0", bus.ready, bus.done);
    end
  endtask

  task automatic test_invalid_addr_cycles();
    int acc;
    clear_log();
    start_req(8'h00, 40'h0, 3'd6, 1'b0, 8'h00, acc);
    wait_end(20);
    checks++;
    if (err_cyc.size() != 1 || (err_cyc.size() == 1 && err_cyc[0] != acc)) begin
      errors++; $display("FAIL invalid_error: pulses=%0d, required 1 at cycle %0d", err_cyc.size(), acc);
    end
    repeat (3) begin @(negedge clk); #1; end
    checks++;
    if (act_cyc.size() != 0 || done_cyc.size() != 0 || err_cyc.size() != 1 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL invalid_after: acts=%0d done=%0d err=%0d ready=%b, required 0 0 1 1",
               act_cyc.size(), done_cyc.size(), err_cyc.size(), bus.ready);
    end
  endtask

  task automatic test_timeout();
    int acc;
    clear_log();
    model_en = 1'b0;
    start_req(8'h70, 40'h0, 3'd0, 1'b0, 8'h00, acc);
    wait_end(40);
    checks++;
    if (err_cyc.size() != 1 || (err_cyc.size() == 1 && err_cyc[0] != acc + 16)) begin
      errors++; $display("FAIL timeout_error: pulses=%0d, required 1 at cycle %0d", err_cyc.size(), acc + 16);
    end
    repeat (2) begin @(negedge clk); #1; end
    checks++;
    if (act_cyc.size() != 1 || done_cyc.size() != 0 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_after: acts=%0d done=%0d ready=%b, required 1 0 1",
               act_cyc.size(), done_cyc.size(), bus.ready);
    end
    model_en = 1'b1;
  endtask

  task automatic test_reset_mid_sequence();
    int acc;
    clear_log();
    start_req(8'h00, 40'h00_0002_0100, 3'd5, 1'b1, 8'h30, acc);
    wait_acts(3, 40);
    // Third byte: ISSUE at a3, WAIT_HI at a3+1, WAIT_LO from a3+2 to a3+5.
    repeat (3) begin @(negedge clk); #1; end
    reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.error !== 1'b0 ||
        bus.latch_activate !== 1'b0 || bus.latch_data !== 16'h0000 || bus.latch_type !== T_CMD) begin
      errors++;
      $display("FAIL midreset_state: rdy=%b done=%b err=%b act=%b data=%h type=%b, required 1 0 0 0 0000 0",
               bus.ready, bus.done, bus.error, bus.latch_activate, bus.latch_data, bus.latch_type);
    end
    reset = 1'b0;
    repeat (20) begin @(negedge clk); #1; end
    checks++;
    if (act_cyc.size() != 3 || done_cyc.size() != 0 || err_cyc.size() != 0) begin
      errors++;
      $display("FAIL midreset_quiet: acts=%0d done=%0d err=%0d, required 3 0 0",
               act_cyc.size(), done_cyc.size(), err_cyc.size());
    end
    clear_log();
    start_req(8'h90, 40'h0, 3'd0, 1'b0, 8'h00, acc);
    wait_end(40);
    checks++;
    if (done_cyc.size() != 1 || act_cyc.size() != 1 || (act_cyc.size() == 1 && act_dat[0] !== 16'h0090)) begin
      errors++;
      $display("FAIL midreset_restart: done=%0d acts=%0d, required 1 done and 1 activate of 0090",
               done_cyc.size(), act_cyc.size());
    end
  endtask

  task automatic test_start_ignored();
    int acc;
    logic [15:0] exp_d [4];
    logic        exp_t [4];
    exp_d = '{16'h0080, 16'h00AA, 16'h00BB, 16'h0010};
    exp_t = '{T_CMD, T_ADDR, T_ADDR, T_CMD};
    clear_log();
    start_req(8'h80, 40'h00_0000_BBAA, 3'd2, 1'b1, 8'h10, acc);
    repeat (3) begin @(negedge clk); #1; end
    bus.start = 1'b1; bus.cmd0 = 8'h55; bus.addr_cycles = 3'd1; bus.has_cmd1 = 1'b0;
    @(negedge clk); #1;
    bus.start = 1'b0;
    wait_end(60);
    repeat (10) begin @(negedge clk); #1; end
    checks++;
    if (act_cyc.size() != 4 || done_cyc.size() != 1 || err_cyc.size() != 0) begin
      errors++;
      $display("FAIL ignored_counts: acts=%0d done=%0d err=%0d, required 4 1 0",
               act_cyc.size(), done_cyc.size(), err_cyc.size());
    end
    for (int i = 0; i < 4 && i < act_cyc.size(); i++) begin
      checks++;
      if (act_dat[i] !== exp_d[i] || act_typ[i] !== exp_t[i]) begin
        errors++;
        $display("FAIL ignored_byte%0d: data=%h type=%b, required %h %b",
                 i, act_dat[i], act_typ[i], exp_d[i], exp_t[i]);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; both_cnt = 0; model_en = 1'b1;
    reset = 1'b1;
    bus.start = 1'b0; bus.cmd0 = '0; bus.addr = '0; bus.addr_cycles = '0;
    bus.has_cmd1 = 1'b0; bus.cmd1 = '0;
    repeat (3) begin @(negedge clk); #1; end
    test_reset();
    reset = 1'b0;
    repeat (2) begin @(negedge clk); #1; end
    test_full_sequence();
    test_single_cmd();
    test_invalid_addr_cycles();
    test_timeout();
    test_reset_mid_sequence();
    test_start_ignored();
    checks++;
    if (both_cnt != 0) begin
      errors++; $display("FAIL done_and_error: overlapping cycles=%0d, required 0", both_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
